// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: synchroniser, tick-based debounce, press/release
// pulses and optional auto-repeat. 'release' and 'repeat' are reserved words, hence *_pulse.
module btn_debounce_multi #(
    parameter int CHANNELS       = 2,
    parameter int TICK_DIV       = 25000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic [CHANNELS-1:0] hold
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    logic [CHANNELS-1:0] norm, sync1, s;
    logic [TW-1:0]       pcnt;
    logic                tick;
    logic [DW-1:0]       dcnt [CHANNELS];
    logic [CHANNELS-1:0] deb_done, rise_ev, fall_ev;
    rpt_state_t          state [CHANNELS];
    rpt_state_t          state_nx [CHANNELS];
    logic [RW-1:0]       rcnt [CHANNELS];
    logic [RW-1:0]       rcnt_nx [CHANNELS];
    logic [CHANNELS-1:0] rep_nx, hold_nx;

    assign norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= norm;
            s     <= sync1;
        end
    end

    assign tick = (pcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        deb_done = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            deb_done[c] = (s[c] != level[c]) && tick && (dcnt[c] == DW'(DEBOUNCE_TICKS - 1));
        end
    end

    assign rise_ev = deb_done & s;
    assign fall_ev = deb_done & ~s;

    // NOTE: per-channel counter arrays are control state, so they are reset like any flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int c = 0; c < CHANNELS; c++) dcnt[c] <= '0;
        end else begin
            press         <= rise_ev;
            release_pulse <= fall_ev;
            for (int c = 0; c < CHANNELS; c++) begin
                if (s[c] == level[c]) begin
                    dcnt[c] <= '0;
                end else if (deb_done[c]) begin
                    level[c] <= s[c];
                    dcnt[c]  <= '0;
                end else if (tick) begin
                    dcnt[c] <= dcnt[c] + 1'b1;
                end
            end
        end
    end

    // Exit (release or enable drop) is tested before expiry so it always wins.
    always_comb begin
        rep_nx  = '0;
        hold_nx = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_nx[c] = state[c];
            rcnt_nx[c]  = rcnt[c];
            case (state[c])
                IDLE: begin
                    if (rise_ev[c] && repeat_en[c]) begin
                        state_nx[c] = DELAY;
                        rcnt_nx[c]  = '0;
                    end
                end
                DELAY, REPEAT: begin
                    if (fall_ev[c] || !repeat_en[c]) begin
                        state_nx[c] = IDLE;
                        rcnt_nx[c]  = '0;
                    end else if (tick) begin
                        if (rcnt[c] == ((state[c] == DELAY) ? RW'(REPEAT_DELAY - 1)
                                                            : RW'(REPEAT_RATE - 1))) begin
                            rep_nx[c]   = 1'b1;
                            rcnt_nx[c]  = '0;
                            state_nx[c] = REPEAT;
                        end else begin
                            rcnt_nx[c] = rcnt[c] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx[c] = IDLE;
                    rcnt_nx[c]  = '0;
                end
            endcase
            hold_nx[c] = (state_nx[c] == REPEAT);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            repeat_pulse <= '0;
            hold         <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                state[c] <= IDLE;
                rcnt[c]  <= '0;
            end
        end else begin
            repeat_pulse <= rep_nx;
            hold         <= hold_nx;
            for (int c = 0; c < CHANNELS; c++) begin
                state[c] <= state_nx[c];
                rcnt[c]  <= rcnt_nx[c];
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: an active-high and an active-low instance checked every
// cycle against a tick-arithmetic reference model, plus directed latency/repeat checks.
module tb_btn_debounce_multi;

    localparam int CH   = 2;
    localparam int T    = 4;
    localparam int D    = 3;
    localparam int DLY  = 5;
    localparam int RATE = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic [1:0][CH-1:0] raw, en;
    logic [1:0][CH-1:0] lvl, prs, rel, rep, hld;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    btn_debounce_multi #(.CHANNELS(CH), .TICK_DIV(T), .DEBOUNCE_TICKS(D), .REPEAT_DELAY(DLY),
                         .REPEAT_RATE(RATE), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rstn(rstn), .btn_raw(raw[0]), .repeat_en(en[0]), .level(lvl[0]),
        .press(prs[0]), .release_pulse(rel[0]), .repeat_pulse(rep[0]), .hold(hld[0]));

    btn_debounce_multi #(.CHANNELS(CH), .TICK_DIV(T), .DEBOUNCE_TICKS(D), .REPEAT_DELAY(DLY),
                         .REPEAT_RATE(RATE), .ACTIVE_LOW(1)) dut_lo (
        .clk(clk), .rstn(rstn), .btn_raw(raw[1]), .repeat_en(en[1]), .level(lvl[1]),
        .press(prs[1]), .release_pulse(rel[1]), .repeat_pulse(rep[1]), .hold(hld[1]));

    // Reference model: edges are numbered from reset release; edge k is a tick edge when
    // k % T == T-1. Level flips once D ticks have passed since the synchronised input last
    // agreed with it; repeats fire at DLY, DLY+RATE, ... ticks after the press edge.
    bit m_sy1 [2][CH], m_sy2 [2][CH], m_lvl [2][CH], m_prs [2][CH], m_rel [2][CH];
    bit m_rep [2][CH], m_hold [2][CH], m_arm [2][CH];
    int m_agree [2][CH], m_start [2][CH];
    int m_edge;

    function automatic int ticks_in(input int a, input int k);
        return (k + 1) / T - (a + 1) / T;
    endfunction

    always @(posedge clk or negedge rstn) begin
        bit m_tick, sv, rise, fall;
        int t;
        if (!rstn) begin
            m_edge = 0;
            for (int u = 0; u < 2; u++) for (int c = 0; c < CH; c++) begin
                m_sy1[u][c] = 0; m_sy2[u][c] = 0; m_lvl[u][c] = 0; m_prs[u][c] = 0;
                m_rel[u][c] = 0; m_rep[u][c] = 0; m_hold[u][c] = 0; m_arm[u][c] = 0;
                m_agree[u][c] = -1; m_start[u][c] = 0;
            end
        end else begin
            m_tick = (m_edge % T) == (T - 1);
            for (int u = 0; u < 2; u++) for (int c = 0; c < CH; c++) begin
                sv = m_sy2[u][c];
                m_sy2[u][c] = m_sy1[u][c];
                m_sy1[u][c] = raw[u][c] ^ (u == 1);
                rise = 0;
                fall = 0;
                if (sv == m_lvl[u][c]) begin
                    m_agree[u][c] = m_edge;
                end else if (m_tick && ticks_in(m_agree[u][c], m_edge) == D) begin
                    m_lvl[u][c]   = sv;
                    rise          = sv;
                    fall          = !sv;
                    m_agree[u][c] = m_edge;
                end
                m_prs[u][c] = rise;
                m_rel[u][c] = fall;
                m_rep[u][c] = 0;
                if (m_arm[u][c] && (fall || !en[u][c])) begin
                    m_arm[u][c] = 0;
                end else if (!m_arm[u][c] && rise && en[u][c]) begin
                    m_arm[u][c]   = 1;
                    m_start[u][c] = m_edge;
                end else if (m_arm[u][c] && m_tick) begin
                    t = ticks_in(m_start[u][c], m_edge);
                    m_rep[u][c] = (t == DLY) || (t > DLY && (t - DLY) % RATE == 0);
                end
                m_hold[u][c] = m_arm[u][c] && ticks_in(m_start[u][c], m_edge) >= DLY;
            end
            m_edge++;
        end
    end

    task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    endtask

    task automatic check_model();
        logic [CH-1:0] el, ep, er, et, eh;
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < CH; c++) begin
                el[c] = m_lvl[u][c]; ep[c] = m_prs[u][c]; er[c] = m_rel[u][c];
                et[c] = m_rep[u][c]; eh[c] = m_hold[u][c];
            end
            chk($sformatf("u%0d_level", u), lvl[u], el);
            chk($sformatf("u%0d_press", u), prs[u], ep);
            chk($sformatf("u%0d_release", u), rel[u], er);
            chk($sformatf("u%0d_repeat", u), rep[u], et);
            chk($sformatf("u%0d_hold", u), hld[u], eh);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_model();
        end
    endtask

    // Waits for a press (sel=0) or release (sel=1) pulse on unit u, channel c.
    task automatic wait_pulse(input int u, input int c, input int sel, input string tag,
                              output int lat);
        bit found = 0;
        lat = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            lat++;
            found = (sel == 0) ? prs[u][c] : rel[u][c];
        end
        chk({tag, "_seen"}, CH'(found), CH'(1));
    endtask

    int  lat, rcount, first, last;
    bit  gaps_ok;
    logic [CH-1:0] acc;

    initial begin
        raw[0] = '0; raw[1] = '1; en = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Idle: everything quiet.
        step(50);
        chk("idle_all", lvl[0] | prs[0] | rel[0] | rep[0] | hld[0], '0);

        // Clean press / release on ch0.
        raw[0] = 2'b01;
        wait_pulse(0, 0, 0, "press", lat);
        chk("press_lat", CH'(lat >= 11 && lat <= 15), CH'(1));
        chk("press_level", lvl[0], 2'b01);
        step(40);
        raw[0] = 2'b00;
        wait_pulse(0, 0, 1, "release", lat);
        chk("release_lat", CH'(lat >= 11 && lat <= 15), CH'(1));
        step(20);

        // Asynchronous reset mid-cycle while pressed.
        raw[0] = 2'b01;
        step(20);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk("async_rst_level", lvl[0], '0);
        @(negedge clk);
        rstn = 1'b1;
        wait_pulse(0, 0, 0, "repress", lat);
        raw[0] = 2'b00;
        step(30);

        // Bounce: toggle every 5 cycles.
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            raw[0][0] = ~raw[0][0];
            for (int j = 0; j < 5; j++) begin
                step(1);
                acc |= lvl[0] | prs[0] | rel[0];
            end
        end
        raw[0] = 2'b00;
        step(20);
        chk("bounce_quiet", acc, '0);

        // Auto-repeat on ch0.
        en[0] = 2'b01;
        raw[0] = 2'b01;
        wait_pulse(0, 0, 0, "rpt_press", lat);
        rcount = 0; first = 0; last = 0; gaps_ok = 1;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (rep[0][0]) begin
                if (rcount == 0) first = i;
                else gaps_ok &= (i - last == 8);
                last = i;
                rcount++;
            end
        end
        chk("rpt_first", CH'(first >= 19 && first <= 21), CH'(1));
        chk("rpt_count", CH'(rcount), CH'(11));
        chk("rpt_gaps", CH'(gaps_ok), CH'(1));
        chk("rpt_hold", hld[0], 2'b01);
        raw[0] = 2'b00;
        wait_pulse(0, 0, 1, "rpt_release", lat);
        chk("rpt_hold_drop", hld[0], '0);
        step(30);

        // repeat_en dropped while in REPEAT.
        raw[0] = 2'b01;
        wait_pulse(0, 0, 0, "en_press", lat);
        step(30);
        en[0] = 2'b00;
        step(1);
        chk("en_drop_hold", hld[0], '0);
        acc = '0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) en[0] = 2'b01;
            step(1);
            acc |= rep[0] | hld[0];
        end
        chk("en_drop_quiet", acc, '0);
        chk("en_drop_level", lvl[0], 2'b01);
        raw[0] = 2'b00;
        step(30);

        // Active-low instance: both pins pressed together, then reset while held.
        raw[1] = 2'b00;
        wait_pulse(1, 0, 0, "al_press", lat);
        chk("al_press_both", prs[1], 2'b11);
        step(10);
        rstn = 1'b0;
        step(3);
        chk("al_rst_level", lvl[1], '0);
        rstn = 1'b1;
        wait_pulse(1, 0, 0, "al_repress", lat);
        chk("al_repress_lat", CH'(lat >= 11 && lat <= 15), CH'(1));
        chk("al_repress_both", prs[1], 2'b11);
        raw[1] = 2'b11;
        step(30);

        // Randomised segments with occasional resets.
        for (int seg = 0; seg < 80; seg++) begin
            raw[0] = CH'($urandom_range(0, 3));
            raw[1] = CH'($urandom_range(0, 3));
            en[0]  = CH'($urandom_range(0, 3));
            en[1]  = CH'($urandom_range(0, 3));
            step(($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 90));
            if ($urandom_range(0, 19) == 0) begin
                rstn = 1'b0;
                step(2);
                rstn = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
